// File: rtl/up_packet_interface_pkg.sv
// Shared types and constants for the uP packet link: FSM states, byte type, packet lengths, commands.
package up_packet_interface_pkg;

   typedef logic [7:0] byte_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RX_WAIT_H1,
      ST_RX_WAIT_H1_LOW,
      ST_EXEC,
      ST_TX_PRESENT,
      ST_TX_WAIT_H1,
      ST_TX_WAIT_H1_LOW,
      ST_DONE
   } up_if_state_t;

   localparam int    NOS_READ_BYTES_FROM_UP = 6;
   localparam int    NOS_WRITE_BYTES_TO_UP  = 8;
   localparam byte_t READ_REGISTER_CMD      = 8'd0;
   localparam byte_t WRITE_REGISTER_CMD     = 8'd1;

   localparam logic [2:0] RX_LAST_IDX = 3'(NOS_READ_BYTES_FROM_UP - 1);
   localparam logic [2:0] TX_LAST_IDX = 3'(NOS_WRITE_BYTES_TO_UP - 1);

   // Reply is {status, rdata}; byte 0 is rdata[7:0], byte 7 is status[31:24].
   function automatic byte_t reply_byte(input logic [63:0] reply, input logic [2:0] idx);
      return reply[{idx, 3'b000} +: 8];
   endfunction

endpackage

// File: rtl/up_packet_interface_input_synchroniser.sv
// Multi-flop synchroniser for one asynchronous uP pin; output lags the pin by SYNC_STAGES clocks.
module input_synchroniser #(
   parameter int SYNC_STAGES = 2
) (
   input  logic i_clk,
   input  logic i_reset,
   input  logic i_async,
   output logic o_sync
);

   logic [SYNC_STAGES-1:0] r_stages;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_stages <= '0;
      end else begin
         r_stages <= {r_stages[SYNC_STAGES-2:0], i_async};
      end
   end

   assign o_sync = r_stages[SYNC_STAGES-1];

endmodule

// File: rtl/up_packet_interface.sv
// Byte-serial uP link: 6-byte command in, one register-bank access, 8-byte reply out, then uP_ack.
// Defining UP_TIMEOUT_EN adds a per-state stall limit (TIMEOUT_CYCLES) that aborts and flags a fault.
module up_packet_interface
   import up_packet_interface_pkg::*;
#(
   parameter int SYNC_STAGES    = 2,
   parameter int TIMEOUT_CYCLES = 1_000_000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        async_uP_start,
   input  logic        async_uP_handshake_1,
   input  logic        async_uP_RW,
   input  logic [7:0]  uP_data_in,
   output logic [7:0]  uP_data_out,
   output logic        uP_data_oe,
   output logic        uP_handshake_2,
   output logic        uP_ack,
   output logic        uP_nFault,
   output logic        bus_req,
   output logic [7:0]  bus_cmd,
   output logic [7:0]  bus_addr,
   output logic [31:0] bus_wdata,
   input  logic        bus_ack,
   input  logic [31:0] bus_rdata,
   input  logic [31:0] bus_status,
   input  logic        bus_fault
);

   logic w_start_s, w_h1_s, w_rw_s;

   up_if_state_t r_state, w_state_nxt;
   logic [2:0]   r_count, w_count_nxt, w_count_inc;
   byte_t        r_pkt [NOS_READ_BYTES_FROM_UP];
   logic [63:0]  r_reply;
   byte_t        r_data_out, w_dout_nxt;
   logic         r_hs2, w_hs2_nxt;
   logic         r_ack, w_ack_nxt;
   logic         r_bus_req, w_req_nxt;
   logic         r_nfault, w_nfault_nxt;
   byte_t        r_bus_cmd, r_bus_addr;
   logic [31:0]  r_bus_wdata;
   logic         w_pkt_we, w_reply_ld, w_bus_ld;
   logic         w_abort, w_timeout, w_tx_phase;

   input_synchroniser #(.SYNC_STAGES(SYNC_STAGES)) u_sync_start (
      .i_clk(clk), .i_reset(reset), .i_async(async_uP_start), .o_sync(w_start_s));
   input_synchroniser #(.SYNC_STAGES(SYNC_STAGES)) u_sync_h1 (
      .i_clk(clk), .i_reset(reset), .i_async(async_uP_handshake_1), .o_sync(w_h1_s));
   input_synchroniser #(.SYNC_STAGES(SYNC_STAGES)) u_sync_rw (
      .i_clk(clk), .i_reset(reset), .i_async(async_uP_RW), .o_sync(w_rw_s));

`ifdef UP_TIMEOUT_EN
   localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);
   logic [31:0] r_stall_cnt;

   always_ff @(posedge clk) begin
      if (reset || r_state == ST_IDLE || w_state_nxt != r_state) begin
         r_stall_cnt <= '0;
      end else begin
         r_stall_cnt <= r_stall_cnt + 32'd1;
      end
   end

   assign w_timeout = (r_state != ST_IDLE) && (r_stall_cnt == TO_LAST);
`else
   logic w_unused_timeout_cfg;
   assign w_unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
   assign w_timeout            = 1'b0;
`endif

   assign w_count_inc = r_count + 3'd1;
   assign w_abort     = (r_state != ST_IDLE) && (r_state != ST_DONE) && !w_start_s;
   assign w_tx_phase  = (r_state == ST_TX_PRESENT) || (r_state == ST_TX_WAIT_H1) ||
                        (r_state == ST_TX_WAIT_H1_LOW);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_count_nxt  = r_count;
      w_hs2_nxt    = r_hs2;
      w_ack_nxt    = r_ack;
      w_dout_nxt   = r_data_out;
      w_req_nxt    = 1'b0;
      w_nfault_nxt = r_nfault;
      w_pkt_we     = 1'b0;
      w_reply_ld   = 1'b0;
      w_bus_ld     = 1'b0;

      case (r_state)
         ST_IDLE: begin
            if (w_start_s) begin
               w_count_nxt = '0;
               w_state_nxt = ST_RX_WAIT_H1;
            end
         end
         ST_RX_WAIT_H1: begin
            if (w_h1_s && w_rw_s) begin
               w_pkt_we    = 1'b1;
               w_hs2_nxt   = 1'b1;
               w_state_nxt = ST_RX_WAIT_H1_LOW;
            end
         end
         ST_RX_WAIT_H1_LOW: begin
            if (!w_h1_s) begin
               w_hs2_nxt   = 1'b0;
               w_count_nxt = w_count_inc;
               if (r_count == RX_LAST_IDX) begin
                  w_req_nxt   = 1'b1;
                  w_bus_ld    = 1'b1;
                  w_state_nxt = ST_EXEC;
               end else begin
                  w_state_nxt = ST_RX_WAIT_H1;
               end
            end
         end
         ST_EXEC: begin
            if (bus_ack) begin
               w_reply_ld   = 1'b1;
               w_nfault_nxt = ~bus_fault;
               w_count_nxt  = '0;
               w_dout_nxt   = bus_rdata[7:0];
               w_state_nxt  = ST_TX_PRESENT;
            end
         end
         // Data was loaded on entry, so it leads the strobe by one cycle.
         ST_TX_PRESENT: begin
            w_hs2_nxt   = 1'b1;
            w_state_nxt = ST_TX_WAIT_H1;
         end
         ST_TX_WAIT_H1: begin
            if (w_h1_s) begin
               w_hs2_nxt   = 1'b0;
               w_state_nxt = ST_TX_WAIT_H1_LOW;
            end
         end
         ST_TX_WAIT_H1_LOW: begin
            if (!w_h1_s) begin
               w_count_nxt = w_count_inc;
               if (r_count == TX_LAST_IDX) begin
                  w_ack_nxt   = 1'b1;
                  w_state_nxt = ST_DONE;
               end else begin
                  w_dout_nxt  = reply_byte(r_reply, w_count_inc);
                  w_state_nxt = ST_TX_PRESENT;
               end
            end
         end
         ST_DONE: begin
            if (!w_start_s) begin
               w_ack_nxt   = 1'b0;
               w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase

      // Abort and stall-out override any progress made this cycle, including a same-cycle bus_ack.
      if (w_abort || w_timeout) begin
         w_state_nxt  = ST_IDLE;
         w_count_nxt  = r_count;
         w_hs2_nxt    = 1'b0;
         w_ack_nxt    = 1'b0;
         w_req_nxt    = 1'b0;
         w_dout_nxt   = r_data_out;
         w_nfault_nxt = w_timeout ? 1'b0 : r_nfault;
         w_pkt_we     = 1'b0;
         w_reply_ld   = 1'b0;
         w_bus_ld     = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_count     <= '0;
         r_hs2       <= 1'b0;
         r_ack       <= 1'b0;
         r_data_out  <= '0;
         r_bus_req   <= 1'b0;
         r_nfault    <= 1'b1;
         r_reply     <= '0;
         r_bus_cmd   <= '0;
         r_bus_addr  <= '0;
         r_bus_wdata <= '0;
         for (int i = 0; i < NOS_READ_BYTES_FROM_UP; i++) begin
            r_pkt[i] <= '0;
         end
      end else begin
         r_count    <= w_count_nxt;
         r_hs2      <= w_hs2_nxt;
         r_ack      <= w_ack_nxt;
         r_data_out <= w_dout_nxt;
         r_bus_req  <= w_req_nxt;
         r_nfault   <= w_nfault_nxt;
         if (w_pkt_we) begin
            r_pkt[r_count] <= uP_data_in;
         end
         if (w_reply_ld) begin
            r_reply <= {bus_status, bus_rdata};
         end
         if (w_bus_ld) begin
            r_bus_cmd   <= r_pkt[0];
            r_bus_addr  <= r_pkt[1];
            r_bus_wdata <= {r_pkt[5], r_pkt[4], r_pkt[3], r_pkt[2]};
         end
      end
   end

   assign uP_data_out    = r_data_out;
   assign uP_data_oe     = w_tx_phase && !w_rw_s;
   assign uP_handshake_2 = r_hs2;
   assign uP_ack         = r_ack;
   assign uP_nFault      = r_nfault;
   assign bus_req        = r_bus_req;
   assign bus_cmd        = r_bus_cmd;
   assign bus_addr       = r_bus_addr;
   assign bus_wdata      = r_bus_wdata;

endmodule

// File: tb/tb_up_packet_interface.sv
// Random and directed uP transactions against a behavioural uP master and register-bank model.
module tb_up_packet_interface;
   import up_packet_interface_pkg::*;

   localparam int SYNC = 2;

   logic        clk;
   logic        reset;
   logic        async_uP_start, async_uP_handshake_1, async_uP_RW;
   logic [7:0]  uP_data_in, uP_data_out;
   logic        uP_data_oe, uP_handshake_2, uP_ack, uP_nFault;
   logic        bus_req, bus_ack, bus_fault;
   logic [7:0]  bus_cmd, bus_addr;
   logic [31:0] bus_wdata, bus_rdata, bus_status;

   int          total = 0;
   int          bad = 0;
   int          req_cycles = 0;
   bit          xact_err;
   logic        last_nf;
   byte_t       prev_dout;
   logic [31:0] bank_status;
   byte_t       cap_cmd, cap_addr;
   logic [31:0] cap_wdata;
   logic [31:0] mem [byte_t];

   up_packet_interface #(.SYNC_STAGES(SYNC), .TIMEOUT_CYCLES(100)) dut (
      .clk(clk), .reset(reset),
      .async_uP_start(async_uP_start), .async_uP_handshake_1(async_uP_handshake_1),
      .async_uP_RW(async_uP_RW), .uP_data_in(uP_data_in), .uP_data_out(uP_data_out),
      .uP_data_oe(uP_data_oe), .uP_handshake_2(uP_handshake_2), .uP_ack(uP_ack),
      .uP_nFault(uP_nFault), .bus_req(bus_req), .bus_cmd(bus_cmd), .bus_addr(bus_addr),
      .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
      .bus_status(bus_status), .bus_fault(bus_fault));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) if (bus_req === 1'b1) req_cycles++;

   task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s act=0x%0h exp=0x%0h", tag, act, exp);
      end
   endtask

   function automatic logic [31:0] default_rd(input byte_t a);
      return {a, 8'h5A, ~a, 8'hC3};
   endfunction

   // Register bank: writes store and echo wdata, reads return stored or default data.
   function automatic logic [63:0] predict(input byte_t c, input byte_t a, input logic [31:0] d,
                                           input logic [31:0] st);
      logic [31:0] rd;
      if (c == WRITE_REGISTER_CMD) rd = d;
      else if (mem.exists(a))      rd = mem[a];
      else                         rd = default_rd(a);
      return {st, rd};
   endfunction

   initial begin : bank
      int lat;
      bus_ack = 1'b0; bus_rdata = '0; bus_status = '0; bus_fault = 1'b0;
      forever begin
         @(negedge clk);
         if (bus_req === 1'b1) begin
            cap_cmd = bus_cmd; cap_addr = bus_addr; cap_wdata = bus_wdata;
            lat = $urandom_range(0, 4);
            repeat (lat) @(negedge clk);
            if (cap_cmd == WRITE_REGISTER_CMD) begin
               mem[cap_addr] = cap_wdata;
               bus_rdata = cap_wdata;
            end else begin
               bus_rdata = mem.exists(cap_addr) ? mem[cap_addr] : default_rd(cap_addr);
            end
            bus_status = bank_status;
            bus_fault  = (cap_addr == 8'hFF) || (cap_cmd > WRITE_REGISTER_CMD);
            bus_ack    = 1'b1;
            @(negedge clk);
            bus_ack = 1'b0; bus_fault = 1'b0; bus_rdata = '0; bus_status = '0;
         end
      end
   end

   task automatic wait_sig(input bit sel_ack, input logic val, input int limit, input string tag,
                           output int n);
      logic cur;
      n = 0;
      forever begin
         @(negedge clk);
         n++;
         cur = sel_ack ? uP_ack : uP_handshake_2;
         if (cur === val) break;
         prev_dout = uP_data_out;
         if (n >= limit) begin
            check_eq(tag, 64'(cur), 64'(val));
            xact_err = 1'b1;
            break;
         end
      end
   endtask

   task automatic send_rx_byte(input byte_t b, output int lat);
      int n;
      uP_data_in = b;
      async_uP_handshake_1 = 1'b1;
      wait_sig(1'b0, 1'b1, 40, "wait_rx_hs2_rise", lat);
      async_uP_handshake_1 = 1'b0;
      if (!xact_err) wait_sig(1'b0, 1'b0, 40, "wait_rx_hs2_fall", n);
   endtask

   task automatic reset_and_check();
      reset = 1'b1;
      async_uP_start = 1'b0; async_uP_handshake_1 = 1'b0; async_uP_RW = 1'b1;
      @(negedge clk);
      check_eq("rst_hs2",   64'(uP_handshake_2), 64'd0);
      check_eq("rst_ack",   64'(uP_ack),         64'd0);
      check_eq("rst_oe",    64'(uP_data_oe),     64'd0);
      check_eq("rst_req",   64'(bus_req),        64'd0);
      check_eq("rst_dout",  64'(uP_data_out),    64'd0);
      check_eq("rst_cmd",   64'(bus_cmd),        64'd0);
      check_eq("rst_addr",  64'(bus_addr),       64'd0);
      check_eq("rst_wdata", 64'(bus_wdata),      64'd0);
      check_eq("rst_nflt",  64'(uP_nFault),      64'd1);
      reset = 1'b0;
      last_nf = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   task automatic up_xact(input byte_t c, input byte_t a, input logic [31:0] d,
                          input logic [63:0] exp_reply, input int rst_at_tx, output bit was_reset);
      byte_t pkt [6];
      byte_t eb;
      int    n;
      was_reset = 1'b0;
      pkt[0] = c; pkt[1] = a;
      for (int k = 0; k < 4; k++) pkt[k+2] = 8'(d >> (8*k));
      xact_err = 1'b0;
      async_uP_RW = 1'b1;
      async_uP_start = 1'b1;
      repeat (4) @(negedge clk);
      for (int i = 0; i < 6 && !xact_err; i++) begin
         send_rx_byte(pkt[i], n);
         if (i == 0 && !xact_err) check_eq("rx_latency", 64'(n), 64'(SYNC + 1));
      end
      if (!xact_err) async_uP_RW = 1'b0;
      for (int i = 0; i < 8 && !xact_err; i++) begin
         eb = 8'(exp_reply >> (8*i));
         wait_sig(1'b0, 1'b1, 100, "wait_tx_hs2_rise", n);
         if (xact_err) break;
         check_eq($sformatf("tx_byte%0d", i),  64'(uP_data_out), 64'(eb));
         check_eq($sformatf("tx_setup%0d", i), 64'(prev_dout),   64'(eb));
         check_eq("tx_oe", 64'(uP_data_oe), 64'd1);
         if (i == rst_at_tx) begin
            reset_and_check();
            was_reset = 1'b1;
            return;
         end
         async_uP_handshake_1 = 1'b1;
         wait_sig(1'b0, 1'b0, 40, "wait_tx_hs2_fall", n);
         check_eq($sformatf("tx_hold%0d", i), 64'(uP_data_out), 64'(eb));
         async_uP_handshake_1 = 1'b0;
      end
      if (!xact_err) begin
         wait_sig(1'b1, 1'b1, 40, "wait_ack_rise", n);
         if (!xact_err) check_eq("done_oe", 64'(uP_data_oe), 64'd0);
      end
      async_uP_start = 1'b0; async_uP_handshake_1 = 1'b0; async_uP_RW = 1'b1;
      if (!xact_err) wait_sig(1'b1, 1'b0, 40, "wait_ack_fall", n);
      else repeat (8) @(negedge clk);
   endtask

   task automatic run_txn(input string name, input byte_t c, input byte_t a, input logic [31:0] d,
                          input logic [31:0] st, input int rst_at_tx);
      int          r0;
      logic        flt;
      logic [63:0] exp;
      bit          was_reset;
      bank_status = st;
      exp = predict(c, a, d, st);
      flt = (a == 8'hFF) || (c > WRITE_REGISTER_CMD);
      r0  = req_cycles;
      up_xact(c, a, d, exp, rst_at_tx, was_reset);
      if (!was_reset) begin
         check_eq({name, "_req_cycles"}, 64'(req_cycles - r0), 64'd1);
         check_eq({name, "_cmd"},   64'(cap_cmd),   64'(c));
         check_eq({name, "_addr"},  64'(cap_addr),  64'(a));
         check_eq({name, "_wdata"}, 64'(cap_wdata), 64'(d));
         check_eq({name, "_nfault"}, 64'(uP_nFault), 64'(!flt));
         last_nf = !flt;
      end
   endtask

   initial begin : main
      int    n, r0;
      byte_t c, a;
      async_uP_start = 1'b0; async_uP_handshake_1 = 1'b0; async_uP_RW = 1'b1;
      uP_data_in = '0; bank_status = '0; prev_dout = '0; xact_err = 1'b0;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      reset_and_check();

      run_txn("wr", WRITE_REGISTER_CMD, 8'h10, 32'h12345678, 32'h0, -1);
      mem[8'h05] = 32'hDEADBEEF;
      run_txn("rd", READ_REGISTER_CMD, 8'h05, 32'h0, 32'h1, -1);
      run_txn("flt", READ_REGISTER_CMD, 8'hFF, 32'h0, $urandom, -1);
      run_txn("rd_after_flt", READ_REGISTER_CMD, 8'h10, 32'h0, 32'h0, -1);

      // Abort during byte 3 while the strobe is still high.
      r0 = req_cycles;
      xact_err = 1'b0;
      async_uP_RW = 1'b1; async_uP_start = 1'b1;
      repeat (4) @(negedge clk);
      for (int i = 0; i < 3; i++) send_rx_byte(8'(i + 1), n);
      uP_data_in = 8'h44;
      async_uP_handshake_1 = 1'b1;
      wait_sig(1'b0, 1'b1, 40, "wait_abort_hs2_rise", n);
      async_uP_start = 1'b0;
      wait_sig(1'b0, 1'b0, 8, "wait_abort_hs2_fall", n);
      check_eq("abort_latency_le4", 64'(n <= 4), 64'd1);
      async_uP_handshake_1 = 1'b0;
      repeat (4) @(negedge clk);
      check_eq("abort_no_req", 64'(req_cycles - r0), 64'd0);
      check_eq("abort_nfault", 64'(uP_nFault), 64'(last_nf));
      check_eq("abort_ack",    64'(uP_ack),    64'd0);
      check_eq("abort_oe",     64'(uP_data_oe), 64'd0);
      run_txn("after_abort", WRITE_REGISTER_CMD, 8'h22, 32'hCAFEF00D, 32'hA5A5_0001, -1);

      run_txn("rst_mid", READ_REGISTER_CMD, 8'h22, 32'h0, 32'h0BADF00D, 4);
      run_txn("after_rst", READ_REGISTER_CMD, 8'h22, 32'h0, 32'h0000_0003, -1);

      for (int t = 0; t < 20; t++) begin
         c = ($urandom_range(0, 9) == 0) ? 8'd2 : 8'($urandom_range(0, 1));
         a = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom_range(0, 15));
         run_txn($sformatf("rnd%0d", t), c, a, $urandom, $urandom, -1);
      end

`ifdef UP_TIMEOUT_EN
      xact_err = 1'b0;
      async_uP_RW = 1'b1; async_uP_start = 1'b1;
      repeat (4) @(negedge clk);
      for (int i = 0; i < 2; i++) send_rx_byte(8'(i + 7), n);
      uP_data_in = 8'h99;
      async_uP_handshake_1 = 1'b1;
      wait_sig(1'b0, 1'b1, 40, "wait_to_hs2_rise", n);
      wait_sig(1'b0, 1'b0, 200, "wait_to_hs2_fall", n);
      check_eq("timeout_cycles", 64'(n >= 98 && n <= 102), 64'd1);
      check_eq("timeout_nfault", 64'(uP_nFault), 64'd0);
      async_uP_start = 1'b0; async_uP_handshake_1 = 1'b0;
      repeat (6) @(negedge clk);
      run_txn("after_timeout", READ_REGISTER_CMD, 8'h05, 32'h0, 32'h7, -1);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/up_packet_interface.md
# up_packet_interface

Byte-serial microprocessor link inside `motion_system`, between the external uP pins and the internal register bank.
- Receives a 6-byte command packet over the 4-wire handshake: command, register address, then 32-bit data LSB first.
- Issues one register-bank transaction, then returns an 8-byte reply: data LSB first, then status LSB first.
- Closes each transaction with `uP_ack`.

## Interface
Parameters:
- `SYNC_STAGES`, 2: synchroniser depth for async uP inputs.
- `TIMEOUT_CYCLES`, 1_000_000: stall limit in clk cycles (used only with `UP_TIMEOUT_EN`).

Ports:
- `clk` in 1: system clock (50 MHz).
- `reset` in 1: synchronous, active-high.
- `async_uP_start` in 1: transaction frame from uP.
- `async_uP_handshake_1` in 1: uP strobe.
- `async_uP_RW` in 1: 1 = uP drives data bus.
- `uP_data_in` in 8: bus value sampled from pins.
- `uP_data_out` out 8: reply byte.
- `uP_data_oe` out 1: tristate enable; top level drives pins when 1.
- `uP_handshake_2` out 1: FPGA strobe.
- `uP_ack` out 1: transaction complete.
- `uP_nFault` out 1: low = last transaction faulted.
- `bus_req` out 1: one-cycle request pulse to the register bank.
- `bus_cmd` out 8: command byte (0 = read, 1 = write).
- `bus_addr` out 8: register address.
- `bus_wdata` out 32: write data.
- `bus_ack` in 1: register bank done; `bus_rdata` and `bus_status` are valid on this cycle.
- `bus_rdata` in 32: register read data.
- `bus_status` in 32: register bank status word.
- `bus_fault` in 1: address unused or command illegal.

## Operation
- All three async inputs pass through `SYNC_STAGES` flip-flops. Every decision below uses the synchronised versions (`start_s`, `h1_s`, `rw_s`).
- **IDLE:** on `start_s` = 1, clear byte counter to 0 and go to RX_WAIT_H1.
- **RX_WAIT_H1:** on `h1_s` = 1 with `rw_s` = 1:
  - latch `uP_data_in` into packet byte [count];
  - set `uP_handshake_2` = 1;
  - go to RX_WAIT_H1_LOW.
- **RX_WAIT_H1_LOW:** on `h1_s` = 0, clear `uP_handshake_2` and increment count. If count was 5, go to EXEC; otherwise go to RX_WAIT_H1.
- **EXEC:** pulse `bus_req` for one cycle, with `bus_cmd`/`bus_addr`/`bus_wdata` held stable from the packet. Wait for `bus_ack`, then:
  - latch `{status, data}` into an 8-byte reply buffer;
  - latch `uP_nFault` = ~`bus_fault`;
  - clear count and go to TX_PRESENT.
- **TX_PRESENT:** drive `uP_data_out` = reply[count]; `uP_data_oe` = ~`rw_s`. One cycle later set `uP_handshake_2` = 1 and go to TX_WAIT_H1.
- **TX_WAIT_H1:** on `h1_s` = 1, clear `uP_handshake_2` and go to TX_WAIT_H1_LOW.
- **TX_WAIT_H1_LOW:** on `h1_s` = 0, increment count. If count was 7, go to DONE; otherwise go to TX_PRESENT.
- **DONE:** set `uP_ack` = 1 and `uP_data_oe` = 0. On `start_s` = 0, clear `uP_ack` and go to IDLE.
- **Abort:** `start_s` falling in any RX/TX state returns to IDLE with all strobes cleared. `uP_nFault` is not updated, and no `bus_req` is issued if the abort happens before EXEC.
- **Bus guard:** `uP_data_oe` is forced to 0 whenever `rw_s` = 1 (contention guard).
- Reply byte order: bytes 0–3 = `bus_rdata` [7:0]…[31:24]; bytes 4–7 = `bus_status` [7:0]…[31:24].

## Timing
- Reset values:
  - state = IDLE;
  - `uP_handshake_2`, `uP_ack`, `uP_data_oe`, `bus_req` = 0;
  - `uP_data_out`, `bus_cmd`, `bus_addr`, `bus_wdata` = 0;
  - `uP_nFault` = 1.
- Reset mid-transaction behaves exactly as power-on reset.
- Input-to-reaction latency: `SYNC_STAGES` + 1 cycles from a pin edge to the registered response (3 cycles at default).
- `bus_req` is asserted the first cycle in EXEC; the reply buffer is loaded on the cycle `bus_ack` = 1.
- `bus_ack` arriving in the same cycle as an abort: the abort wins and the reply is discarded.
- `uP_data_out` is stable at least 1 cycle before `uP_handshake_2` rises, and is held until `h1_s` falls.
- Byte counter is 3 bits and never wraps within a phase. It is cleared on entry to each phase.

## Configuration
- `UP_TIMEOUT_EN` defined:
  - a 32-bit stall counter clears on every state change;
  - reaching `TIMEOUT_CYCLES` in any non-IDLE state forces IDLE (as for abort) and sets `uP_nFault` = 0.
- `UP_TIMEOUT_EN` undefined: no counter exists; the block waits indefinitely.

## Structure
- Shared `types` package:
  - state enum `up_if_state_t`;
  - `byte_t`.
- Shared `global_constants`:
  - `` `NOS_READ_BYTES_FROM_UP`` = 6 and `` `NOS_WRITE_BYTES_TO_UP`` = 8;
  - `` `READ_REGISTER_CMD`` = 0 and `` `WRITE_REGISTER_CMD`` = 1.
- Sub-module `input_synchroniser` (parameter `SYNC_STAGES`, width 1), instantiated three times.

## Test plan
- **Write:** write command 1, address 0x10, data 0x12345678 → one `bus_req` with `bus_cmd` = 1, `bus_addr` = 0x10, `bus_wdata` = 0x12345678. Bank returns rdata 0x12345678, status 0 → reply bytes 78 56 34 12 00 00 00 00, then `uP_ack` = 1.
- **Read:** read command 0, address 0x05, bank rdata 0xDEADBEEF, status 0x00000001 → reply EF BE AD DE 01 00 00 00, `uP_nFault` = 1.
- **Fault:** read of unused address 0xFF with `bus_fault` = 1 → `uP_nFault` = 0 after EXEC; next good transaction restores it to 1.
- **Abort:** drop `async_uP_start` after byte 3 → back to IDLE within 4 cycles, no `bus_req`, `uP_handshake_2` = 0.
- **Reset:** assert `reset` during TX byte 4 → all outputs at reset values next cycle; a following full transaction completes normally.
- **Timeout:** with `UP_TIMEOUT_EN` and `TIMEOUT_CYCLES` = 100, hold `handshake_1` high after byte 2 → IDLE after 100 cycles, `uP_nFault` = 0.
